blob_tracker: RTL

- Parametrised successor of the single-frame three-region vision core for the OV5640 binary-image path.
- Consumes one thresholded line per handshake and labels runs into up to MAX_BLOBS blob slots. Each slot accumulates a bounding box and a pixel count.
- At frame end, streams one record per valid blob (bbox, centroid, count) over a valid/ready interface to the downstream classifier.

---
 rtl/blob_tracker.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/blob_tracker.sv
// blob_tracker: labels runs of a binary frame into bbox/count slots and streams
// one record per blob at frame end. Optional build macro: BLOB_SIZE_FILTER_EN.
module blob_tracker #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int MAX_BLOBS = 4,
  parameter int X_TOL     = 4,
  parameter int Y_GAP     = 2,
  parameter int CNT_W     = 17,
  parameter int MIN_AREA  = 16,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H),
  localparam int IW = (MAX_BLOBS > 1) ? $clog2(MAX_BLOBS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [IMG_W-1:0] line_pixel,
  input  logic             line_valid,
  output logic             line_ready,
  output logic             blob_valid,
  input  logic             blob_ready,
  output logic [IW-1:0]    blob_idx,
  output logic [XW-1:0]    blob_xmin,
  output logic [XW-1:0]    blob_xmax,
  output logic [YW-1:0]    blob_ymin,
  output logic [YW-1:0]    blob_ymax,
  output logic [XW-1:0]    blob_cx,
  output logic [YW-1:0]    blob_cy,
  output logic [CNT_W-1:0] blob_count,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // blob_valid/blob_* hold steady until that edge; line_ready is a pure function
  // of state and line_pixel is sampled only on the transfer edge.
  typedef enum logic [2:0] {IDLE, WAIT_LINE, SCAN, MERGE, LINE_END, REPORT, DONE} state_e;

  localparam logic [XW:0]   XTOL_V = (XW+1)'(X_TOL);
  localparam logic [YW:0]   YGAP_V = (YW+1)'(Y_GAP);
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W-1);

  state_e state, state_nxt;

  logic [IMG_W-1:0] line_q, line_l, line_r;
  logic [XW-1:0]    col, run_start, run_end;
  logic [YW-1:0]    row;
  logic [IW-1:0]    ridx;

  logic             s_valid [MAX_BLOBS];
  logic [XW-1:0]    s_xmin  [MAX_BLOBS];
  logic [XW-1:0]    s_xmax  [MAX_BLOBS];
  logic [YW-1:0]    s_ymin  [MAX_BLOBS];
  logic [YW-1:0]    s_ymax  [MAX_BLOBS];
  logic [CNT_W-1:0] s_count [MAX_BLOBS];

  logic             slot_hit [MAX_BLOBS];
  logic             match_hit, free_hit;
  logic [IW-1:0]    match_idx, free_idx;
  logic             pix, run_begin, run_close, col_last, row_last, ridx_last;
  logic [XW:0]      run_len, cx_sum;
  logic [YW:0]      cy_sum;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_new;
  logic             area_ok, report_ok, rep_step;

  // Neighbour views: line_l[c] is column c-1, line_r[c] is column c+1, edges read 0.
  assign line_l    = {line_q[IMG_W-2:0], 1'b0};
  assign line_r    = {1'b0, line_q[IMG_W-1:1]};
  assign pix       = line_q[col];
  assign run_begin = pix && !line_l[col];
  assign run_close = pix && !line_r[col];
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == YW'(IMG_H-1));
  assign ridx_last = (ridx == IW'(MAX_BLOBS-1));

  always_comb begin
    for (int i = 0; i < MAX_BLOBS; i++) begin
      slot_hit[i] = s_valid[i]
                 && ({1'b0, row - s_ymax[i]} <= YGAP_V)
                 && ({1'b0, run_start} <= {1'b0, s_xmax[i]} + XTOL_V)
                 && ({1'b0, run_end} + XTOL_V >= {1'b0, s_xmin[i]});
    end
  end

  // Descending scan so the lowest index wins for both match and allocation.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = MAX_BLOBS-1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!s_valid[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign run_len = {1'b0, run_end} - {1'b0, run_start} + (XW+1)'(1);
  assign cnt_sum = {1'b0, s_count[match_idx]} + (CNT_W+1)'(run_len);
  assign cnt_new = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  assign cx_sum  = {1'b0, s_xmin[ridx]} + {1'b0, s_xmax[ridx]};
  assign cy_sum  = {1'b0, s_ymin[ridx]} + {1'b0, s_ymax[ridx]};

`ifdef BLOB_SIZE_FILTER_EN
  assign area_ok = (s_count[ridx] >= CNT_W'(MIN_AREA));
`else
  assign area_ok = 1'b1;
`endif

  assign report_ok = s_valid[ridx] && area_ok;
  assign rep_step  = blob_valid ? blob_ready : !report_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = IDLE;
      WAIT_LINE: if (line_valid) state_nxt = SCAN;
      SCAN: begin
        if (run_close)     state_nxt = MERGE;
        else if (col_last) state_nxt = LINE_END;
      end
      MERGE:     state_nxt = (run_end == COL_LAST) ? LINE_END : SCAN;
      LINE_END:  state_nxt = row_last ? REPORT : WAIT_LINE;
      REPORT:    if (rep_step && ridx_last) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = WAIT_LINE;
  end

  assign line_ready = (state == WAIT_LINE);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q     <= '0;
      col        <= '0;
      row        <= '0;
      run_start  <= '0;
      run_end    <= '0;
      ridx       <= '0;
      overflow   <= 1'b0;
      blob_valid <= 1'b0;
      blob_idx   <= '0;
      blob_xmin  <= '0;
      blob_xmax  <= '0;
      blob_ymin  <= '0;
      blob_ymax  <= '0;
      blob_cx    <= '0;
      blob_cy    <= '0;
      blob_count <= '0;
      for (int i = 0; i < MAX_BLOBS; i++) begin
        s_valid[i] <= 1'b0;
        s_xmin[i]  <= '0;
        s_xmax[i]  <= '0;
        s_ymin[i]  <= '0;
        s_ymax[i]  <= '0;
        s_count[i] <= '0;
      end
    end else if (frame_start) begin
      col        <= '0;
      row        <= '0;
      ridx       <= '0;
      overflow   <= 1'b0;
      blob_valid <= 1'b0;
      for (int i = 0; i < MAX_BLOBS; i++) s_valid[i] <= 1'b0;
    end else begin
      case (state)
        WAIT_LINE: if (line_valid) begin
          line_q <= line_pixel;
          col    <= '0;
        end
        SCAN: begin
          if (run_begin) run_start <= col;
          if (run_close)     run_end <= col;
          else if (!col_last) col    <= col + 1'b1;
        end
        MERGE: begin
          if (match_hit) begin
            if (run_start < s_xmin[match_idx]) s_xmin[match_idx] <= run_start;
            if (run_end > s_xmax[match_idx])   s_xmax[match_idx] <= run_end;
            s_ymax[match_idx]  <= row;
            s_count[match_idx] <= cnt_new;
          end else if (free_hit) begin
            s_valid[free_idx] <= 1'b1;
            s_xmin[free_idx]  <= run_start;
            s_xmax[free_idx]  <= run_end;
            s_ymin[free_idx]  <= row;
            s_ymax[free_idx]  <= row;
            s_count[free_idx] <= CNT_W'(run_len);
          end else begin
            overflow <= 1'b1;
          end
          if (run_end != COL_LAST) col <= col + 1'b1;
        end
        LINE_END: begin
          if (row_last) ridx <= '0;
          else          row  <= row + 1'b1;
        end
        REPORT: begin
          if (blob_valid) begin
            if (blob_ready) begin
              blob_valid <= 1'b0;
              if (!ridx_last) ridx <= ridx + 1'b1;
            end
          end else if (report_ok) begin
            blob_valid <= 1'b1;
            blob_idx   <= ridx;
            blob_xmin  <= s_xmin[ridx];
            blob_xmax  <= s_xmax[ridx];
            blob_ymin  <= s_ymin[ridx];
            blob_ymax  <= s_ymax[ridx];
            blob_cx    <= XW'(cx_sum >> 1);
            blob_cy    <= YW'(cy_sum >> 1);
            blob_count <= s_count[ridx];
          end else if (!ridx_last) begin
            ridx <= ridx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
